// File: rtl/vme_stat_seq_pkg.sv
// vme_stat_pkg: shared types and constants for the DMB status-register
// sequencer (vme_stat_seq) and its interface.
//   state_t   sequencer FSM states
//   SEL_CTRL  COMMAND[2:0] value that addresses the local control register
//   TMO_DATA  word returned when a status source never acknowledges
//   DW        VME data width
package vme_stat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_REQ,
    ST_DRIVE,
    ST_ACKED,
    ST_WAITREL
  } state_t;

  localparam logic [2:0]  SEL_CTRL = 3'd7;
  localparam logic [15:0] TMO_DATA = 16'hDEAD;
  localparam int unsigned DW       = 16;

endpackage

// File: rtl/vme_stat_seq_if.sv
// vme_stat_seq_if: VME slave-side bus plus status-source request bus.
//   STROBE/WRITE_B/DEVICE/COMMAND/INDATA : VME cycle inputs from the decoder
//   OUTDATA/OE/DTACK_B                   : VME read data, drive enable, ack
//   SRC_REQ/SRC_ACK/SRC_DATA             : one-hot request / ack / packed words
// Modports: slave = sequencer view, master = decoder + sources view.
interface vme_stat_seq_if #(
  parameter int unsigned NSRC = 4
);
  import vme_stat_pkg::*;

  logic                 STROBE;
  logic                 WRITE_B;
  logic                 DEVICE;
  logic [9:0]           COMMAND;
  logic [DW-1:0]        INDATA;
  logic [DW-1:0]        OUTDATA;
  logic                 OE;
  logic                 DTACK_B;
  logic [NSRC-1:0]      SRC_REQ;
  logic [NSRC-1:0]      SRC_ACK;
  logic [DW*NSRC-1:0]   SRC_DATA;

  modport slave (
    input  STROBE, WRITE_B, DEVICE, COMMAND, INDATA, SRC_ACK, SRC_DATA,
    output OUTDATA, OE, DTACK_B, SRC_REQ
  );

  modport master (
    output STROBE, WRITE_B, DEVICE, COMMAND, INDATA, SRC_ACK, SRC_DATA,
    input  OUTDATA, OE, DTACK_B, SRC_REQ
  );
endinterface

// File: rtl/vme_stat_seq_stb_sync.sv
// vme_stb_sync: 2-flop synchroniser for the asynchronous VME strobe, with a
// third flop to produce a one-cycle rising-edge pulse.
//   clk_i  clock          rst_ni  async active-low reset
//   d_i    async level    lvl_o   synchronised level    rise_o  rising pulse
module vme_stb_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o
);
  logic [2:0] sh_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sh_q <= '0;
    else         sh_q <= {sh_q[1:0], d_i};
  end

  assign lvl_o  = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/vme_stat_seq.sv
// vme_stat_seq: VME slave-cycle sequencer for the DMB status-register device.
// Synchronises STROBE, decodes COMMAND[2:0], fetches one word from one of NSRC
// status sources (or the local CTRL register at select 7), and runs DTACK.
//   FASTCLK   clock                 RST_B     async active-low reset
//   bus       vme_stat_seq_if.slave (VME cycle signals + source req/ack/data)
//   CTRL      local control register
//   TMO_FLAG  sticky source-timeout flag
// Optional feature macro: VME_STAT_TMO_EN (source-ack timeout of TMO_CYC cycles).
module vme_stat_seq
  import vme_stat_pkg::*;
#(
  parameter int unsigned NSRC    = 4,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic                FASTCLK,
  input  logic                RST_B,
  vme_stat_seq_if.slave       bus,
  output logic [DW-1:0]       CTRL,
  output logic                TMO_FLAG
);

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   ctrl_q, ctrl_d;
  logic [NSRC-1:0] req_q, req_d;
  logic            cyc_we_q, cyc_we_d;
  logic [2:0]      cyc_sel_q, cyc_sel_d;
  logic [DW-1:0]   cyc_wdata_q, cyc_wdata_d;
  logic            stb_s, stb_rise;
  logic [NSRC-1:0] sel_hot;
  logic            sel_is_src, ack_sel;
  logic [DW-1:0]   word_sel;
  logic            cmd_unused;

  assign cmd_unused = ^bus.COMMAND[9:3];

  vme_stb_sync u_sync (
    .clk_i  (FASTCLK),
    .rst_ni (RST_B),
    .d_i    (bus.STROBE),
    .lvl_o  (stb_s),
    .rise_o (stb_rise)
  );

  // Select decode done per source so no index is wider than the source vector.
  always_comb begin
    sel_hot  = '0;
    word_sel = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      sel_hot[i] = (cyc_sel_q == 3'(i));
      if (sel_hot[i]) word_sel = bus.SRC_DATA[DW*i +: DW];
    end
    sel_is_src = |sel_hot;
    ack_sel    = |(sel_hot & bus.SRC_ACK);
  end

`ifdef VME_STAT_TMO_EN
  localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_flag_q, tmo_flag_d;
`else
  logic [7:0] tmo_cfg_unused;
  assign tmo_cfg_unused = 8'(TMO_CYC);
`endif

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    req_d       = req_q;
    cyc_we_d    = cyc_we_q;
    cyc_sel_d   = cyc_sel_q;
    cyc_wdata_d = cyc_wdata_q;
`ifdef VME_STAT_TMO_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_flag_d  = tmo_flag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (stb_rise) begin
          cyc_we_d    = ~bus.WRITE_B;
          cyc_sel_d   = bus.COMMAND[2:0];
          cyc_wdata_d = bus.INDATA;
          state_d     = bus.DEVICE ? ST_DECODE : ST_WAITREL;
        end
      end
      ST_DECODE: begin
        if (!stb_s) begin
          state_d = ST_WAITREL;
        end else if (!cyc_we_q && sel_is_src) begin
          req_d   = sel_hot;
          state_d = ST_REQ;
`ifdef VME_STAT_TMO_EN
          tmo_cnt_d = '0;
`endif
        end else if (cyc_sel_q == SEL_CTRL) begin
          // CTRL writes also pass through DRIVE (OE stays low) so that both
          // CTRL reads and writes acknowledge 3 cycles after stb_s rises.
          if (cyc_we_q) begin
`ifdef VME_STAT_TMO_EN
            ctrl_d = {1'b0, cyc_wdata_q[DW-2:0]};
            if (cyc_wdata_q[DW-1]) tmo_flag_d = 1'b0;
`else
            ctrl_d = cyc_wdata_q;
`endif
          end else begin
            data_d = ctrl_q;
          end
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_WAITREL;
        end
      end
      ST_REQ: begin
        if (!stb_s) begin
          req_d   = '0;
          state_d = ST_WAITREL;
        end else if (ack_sel) begin
          data_d  = word_sel;
          req_d   = '0;
          state_d = ST_DRIVE;
        end
`ifdef VME_STAT_TMO_EN
        else if (tmo_cnt_q == TMO_LIM) begin
          data_d     = TMO_DATA;
          req_d      = '0;
          tmo_flag_d = 1'b1;
          state_d    = ST_DRIVE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      ST_DRIVE:   state_d = stb_s ? ST_ACKED : ST_WAITREL;
      ST_ACKED:   if (!stb_s) state_d = ST_WAITREL;
      ST_WAITREL: if (!stb_s) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge FASTCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      ctrl_q      <= '0;
      req_q       <= '0;
      cyc_we_q    <= 1'b0;
      cyc_sel_q   <= '0;
      cyc_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      req_q       <= req_d;
      cyc_we_q    <= cyc_we_d;
      cyc_sel_q   <= cyc_sel_d;
      cyc_wdata_q <= cyc_wdata_d;
    end
  end

`ifdef VME_STAT_TMO_EN
  always_ff @(posedge FASTCLK or negedge RST_B) begin
    if (!RST_B) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end
  assign TMO_FLAG = tmo_flag_q;
`else
  assign TMO_FLAG = 1'b0;
`endif

  assign bus.OUTDATA = data_q;
  assign bus.OE      = ((state_q == ST_DRIVE) || (state_q == ST_ACKED)) && !cyc_we_q;
  assign bus.DTACK_B = (state_q != ST_ACKED);
  assign bus.SRC_REQ = req_q;
  assign CTRL        = ctrl_q;

endmodule

// File: tb/tb_vme_stat_seq.sv
module tb_vme_stat_seq;
  logic        clk = 1'b0;
  logic        rst_b;
  logic [15:0] ctrl;
  logic        tmo_flag;
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  vme_stat_seq_if #(.NSRC(4)) bus ();

  vme_stat_seq #(.NSRC(4), .TMO_CYC(255)) dut (
    .FASTCLK  (clk),
    .RST_B    (rst_b),
    .bus      (bus.slave),
    .CTRL     (ctrl),
    .TMO_FLAG (tmo_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int unsigned n = 1);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise STROBE just after an edge; stb_s rises two edges later.
  task automatic start_cycle(input logic dev, input logic wb, input logic [9:0] cmd,
                             input logic [15:0] din);
    bus.DEVICE  = dev;
    bus.WRITE_B = wb;
    bus.COMMAND = cmd;
    bus.INDATA  = din;
    bus.STROBE  = 1'b1;
  endtask

  // Drop STROBE and let the FSM return to IDLE; DTACK must be released.
  task automatic release_cycle(input string tag);
    bus.STROBE = 1'b0;
    tick(4);
    chk({tag, "_rel_dtack"}, 32'(bus.DTACK_B), 32'd1);
    chk({tag, "_rel_oe"}, 32'(bus.OE), 32'd0);
    tick(1);
  endtask

  initial begin
    bus.STROBE   = 1'b0;
    bus.DEVICE   = 1'b0;
    bus.WRITE_B  = 1'b1;
    bus.COMMAND  = '0;
    bus.INDATA   = '0;
    bus.SRC_ACK  = '0;
    bus.SRC_DATA = {16'h4444, 16'h3333, 16'h2222, 16'h7E1B};
    rst_b = 1'b0;
    tick(2);
    chk("rst_dtack", 32'(bus.DTACK_B), 32'd1);
    chk("rst_oe", 32'(bus.OE), 32'd0);
    chk("rst_req", 32'(bus.SRC_REQ), 32'd0);
    chk("rst_outdata", 32'(bus.OUTDATA), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_tmo", 32'(tmo_flag), 32'd0);
    rst_b = 1'b1;
    tick(2);

    // 1: read source 0, ack in second REQ cycle; stray ack on source 1 ignored
    start_cycle(1'b1, 1'b1, 10'd0, 16'h0);
    tick(4);
    chk("t1_req_on", 32'(bus.SRC_REQ), 32'h1);
    chk("t1_dtack_e4", 32'(bus.DTACK_B), 32'd1);
    bus.SRC_ACK = 4'b0010;
    tick(1);
    chk("t1_req_held", 32'(bus.SRC_REQ), 32'h1);
    chk("t1_dtack_e5", 32'(bus.DTACK_B), 32'd1);
    bus.SRC_ACK = 4'b0001;
    tick(1);
    chk("t1_req_off", 32'(bus.SRC_REQ), 32'h0);
    chk("t1_oe_drive", 32'(bus.OE), 32'd1);
    chk("t1_data_drive", 32'(bus.OUTDATA), 32'h7E1B);
    chk("t1_dtack_e6", 32'(bus.DTACK_B), 32'd1);
    bus.SRC_ACK = 4'b0000;
    tick(1);
    chk("t1_dtack_low", 32'(bus.DTACK_B), 32'd0);
    chk("t1_data_acked", 32'(bus.OUTDATA), 32'h7E1B);
    tick(3);
    chk("t1_dtack_hold", 32'(bus.DTACK_B), 32'd0);
    bus.STROBE = 1'b0;
    tick(2);
    chk("t1_dtack_hold_rel", 32'(bus.DTACK_B), 32'd0);
    tick(1);
    chk("t1_dtack_released", 32'(bus.DTACK_B), 32'd1);
    chk("t1_oe_released", 32'(bus.OE), 32'd0);
    tick(2);

    // 2: write CTRL then read it back, 3 cycles from stb_s each
    start_cycle(1'b1, 1'b0, 10'd7, 16'h00A5);
    tick(4);
    chk("t2w_ctrl", 32'(ctrl), 32'h00A5);
    chk("t2w_dtack_e4", 32'(bus.DTACK_B), 32'd1);
    tick(1);
    chk("t2w_dtack_low", 32'(bus.DTACK_B), 32'd0);
    chk("t2w_oe", 32'(bus.OE), 32'd0);
    release_cycle("t2w");
    start_cycle(1'b1, 1'b1, 10'h3F8 | 10'd7, 16'h0);
    tick(4);
    chk("t2r_dtack_e4", 32'(bus.DTACK_B), 32'd1);
    chk("t2r_oe_drive", 32'(bus.OE), 32'd1);
    tick(1);
    chk("t2r_dtack_low", 32'(bus.DTACK_B), 32'd0);
    chk("t2r_data", 32'(bus.OUTDATA), 32'h00A5);
    release_cycle("t2r");

    // 3: DEVICE=0, then unimplemented select 5: no request, no DTACK
    start_cycle(1'b0, 1'b1, 10'd0, 16'h0);
    tick(6);
    chk("t3a_req", 32'(bus.SRC_REQ), 32'h0);
    chk("t3a_dtack", 32'(bus.DTACK_B), 32'd1);
    release_cycle("t3a");
    start_cycle(1'b1, 1'b1, 10'd5, 16'h0);
    tick(6);
    chk("t3b_req", 32'(bus.SRC_REQ), 32'h0);
    chk("t3b_dtack", 32'(bus.DTACK_B), 32'd1);
    release_cycle("t3b");
    start_cycle(1'b1, 1'b0, 10'd2, 16'h1111);
    tick(6);
    chk("t3c_dtack", 32'(bus.DTACK_B), 32'd1);
    chk("t3c_ctrl", 32'(ctrl), 32'h00A5);
    release_cycle("t3c");

    // 4: abort in REQ, then a normal read of source 2
    start_cycle(1'b1, 1'b1, 10'd1, 16'h0);
    tick(4);
    chk("t4_req_on", 32'(bus.SRC_REQ), 32'h2);
    tick(3);
    bus.STROBE = 1'b0;
    tick(2);
    chk("t4_dtack_abort", 32'(bus.DTACK_B), 32'd1);
    tick(1);
    chk("t4_req_cleared", 32'(bus.SRC_REQ), 32'h0);
    chk("t4_dtack_after", 32'(bus.DTACK_B), 32'd1);
    tick(3);
    start_cycle(1'b1, 1'b1, 10'd2, 16'h0);
    tick(4);
    chk("t4n_req_on", 32'(bus.SRC_REQ), 32'h4);
    bus.SRC_ACK = 4'b0100;
    tick(1);
    bus.SRC_ACK = 4'b0000;
    chk("t4n_data", 32'(bus.OUTDATA), 32'h3333);
    tick(1);
    chk("t4n_dtack_low", 32'(bus.DTACK_B), 32'd0);
    release_cycle("t4n");

`ifdef VME_STAT_TMO_EN
    // 5: source 3 never acknowledges -> DEAD after timeout
    begin
      bit seen = 1'b0;
      start_cycle(1'b1, 1'b1, 10'd3, 16'h0);
      for (int unsigned k = 0; k < 400 && !seen; k++) begin
        tick(1);
        if (bus.DTACK_B == 1'b0) seen = 1'b1;
      end
      chk("t5_dtack_seen", 32'(seen), 32'd1);
      chk("t5_data", 32'(bus.OUTDATA), 32'hDEAD);
      chk("t5_flag", 32'(tmo_flag), 32'd1);
      chk("t5_req", 32'(bus.SRC_REQ), 32'h0);
      release_cycle("t5");
      start_cycle(1'b1, 1'b0, 10'd7, 16'h8000);
      tick(5);
      chk("t5_flag_clr", 32'(tmo_flag), 32'd0);
      chk("t5_ctrl", 32'(ctrl), 32'h0000);
      release_cycle("t5c");
    end
`else
    chk("t5_flag_tied", 32'(tmo_flag), 32'd0);
`endif

    // 6: asynchronous reset while DTACK is asserted
    start_cycle(1'b1, 1'b0, 10'd7, 16'h1234);
    tick(5);
    chk("t6_ctrl_set", 32'(ctrl), 32'h1234);
    release_cycle("t6w");
    start_cycle(1'b1, 1'b1, 10'd7, 16'h0);
    tick(5);
    chk("t6_dtack_low", 32'(bus.DTACK_B), 32'd0);
    #2 rst_b = 1'b0;
    #1;
    chk("t6_dtack_rst", 32'(bus.DTACK_B), 32'd1);
    chk("t6_oe_rst", 32'(bus.OE), 32'd0);
    chk("t6_ctrl_rst", 32'(ctrl), 32'd0);
    chk("t6_data_rst", 32'(bus.OUTDATA), 32'd0);
    bus.STROBE = 1'b0;
    tick(3);
    rst_b = 1'b1;
    tick(3);
    chk("t6_idle_dtack", 32'(bus.DTACK_B), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
